// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side prediction request/response and execute-side update bundle
// for the gshare branch predictor.
interface gshare_branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 8,
  parameter int GHR_W = 8
);
  logic             pred_valid;
  logic [XLEN-1:0]  pred_pc;
  logic [31:0]      pred_instr;
  logic             pred_ready;
  logic             pred_is_branch;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_mispredict;
  logic [GHR_W-1:0] upd_ghr;

  modport master (
    output pred_valid, pred_pc, pred_instr,
    output upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    input  pred_ready, pred_is_branch, pred_taken, pred_idx, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc, pred_instr,
    input  upd_valid, upd_idx, upd_taken, upd_mispredict, upd_ghr,
    output pred_ready, pred_is_branch, pred_taken, pred_idx, pred_ghr
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare direction predictor with saturating counters, speculative
// global history with mispredict repair, and a post-reset table init sweep.
module gshare_branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 8,
  parameter int GHR_W    = 8,
  parameter int CTR_W    = 2,
  parameter int HASH     = 1,
  parameter int INIT_CTR = 2**(CTR_W-1)-1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  gshare_branch_predictor_if.slave bp
);

  localparam int               ENTRIES  = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);
  localparam logic [6:0]       OP_B     = 7'b1100011;
  localparam logic [6:0]       OP_JAL   = 7'b1101111;
  localparam logic [6:0]       OP_JALR  = 7'b1100111;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sweep_q;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0] tbl_q [ENTRIES];

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] ctr);
    return (ctr == CTR_MAX) ? ctr : ctr + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] ctr);
    return (ctr == '0) ? ctr : ctr - CTR_W'(1);
  endfunction

  logic             ready;
  logic [6:0]       opcode;
  logic             is_b, is_j;
  logic [IDX_W-1:0] pc_idx, idx;
  logic [CTR_W-1:0] ctr_rd;
  logic             taken_raw;
  logic [GHR_W-1:0] spec_ghr, rep_ghr;
  logic             unused_bits;

  assign ready     = (state_q == ST_READY);
  assign opcode    = bp.pred_instr[6:0];
  assign is_b      = (opcode == OP_B);
  assign is_j      = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign pc_idx    = bp.pred_pc[IDX_W+1:2];
  assign idx       = (HASH != 0) ? (pc_idx ^ IDX_W'(ghr_q)) : pc_idx;
  assign ctr_rd    = tbl_q[idx];
  assign taken_raw = is_j | (is_b & ctr_rd[CTR_W-1]);

  // Everything is masked to zero until the table holds valid counters.
  assign bp.pred_ready     = ready;
  assign bp.pred_is_branch = ready & (is_b | is_j);
  assign bp.pred_taken     = ready & taken_raw;
  assign bp.pred_idx       = ready ? idx   : '0;
  assign bp.pred_ghr       = ready ? ghr_q : '0;

  assign unused_bits = ^{bp.pred_pc, bp.pred_instr, bp.upd_ghr, ctr_rd};

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign spec_ghr = taken_raw;
      assign rep_ghr  = bp.upd_taken;
    end else begin : g_ghrn
      assign spec_ghr = {ghr_q[GHR_W-2:0], taken_raw};
      assign rep_ghr  = {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
    end
  endgenerate

  // Repair from execute wins over a same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (ready) begin
      if (bp.upd_valid && bp.upd_mispredict) begin
        ghr_d = rep_ghr;
      end else if (bp.pred_valid && is_b) begin
        ghr_d = spec_ghr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + IDX_W'(1);
          if (sweep_q == IDX_W'(ENTRIES-1)) begin
            state_q <= ST_READY;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Table storage is deliberately not reset; the INIT sweep fills it.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      tbl_q[sweep_q] <= CTR_INIT;
    end else if (bp.upd_valid) begin
      tbl_q[bp.upd_idx] <= bp.upd_taken ? sat_inc(tbl_q[bp.upd_idx])
                                        : sat_dec(tbl_q[bp.upd_idx]);
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor (HASH=1, 8-bit index/history, 2-bit counters).
module tb_gshare_branch_predictor;

  localparam logic [31:0] I_B    = 32'h00208663;
  localparam logic [31:0] I_JAL  = 32'h100000EF;
  localparam logic [31:0] I_JALR = 32'h00008067;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.XLEN(32), .IDX_W(8), .GHR_W(8)) bp_if ();

  gshare_branch_predictor #(
    .XLEN(32), .IDX_W(8), .GHR_W(8), .CTR_W(2), .HASH(1)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bp_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ready;
    logic       isb;
    logic       tk;
    logic [7:0] idx;
    logic [7:0] ghr;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] m_tbl [256];
  logic [7:0] m_ghr;
  logic       m_ready;
  int         m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_pred(input logic [31:0] pc, input logic [31:0] instr);
    exp_t       e;
    logic [6:0] op;
    logic       b, j;
    logic [7:0] ix;
    e  = '0;
    op = instr[6:0];
    b  = (op == 7'h63);
    j  = (op == 7'h6F) || (op == 7'h67);
    ix = pc[9:2] ^ m_ghr;
    if (m_ready) begin
      e.ready = 1'b1;
      e.isb   = b | j;
      e.tk    = j | (b & m_tbl[ix][1]);
      e.idx   = ix;
      e.ghr   = m_ghr;
    end
    return e;
  endfunction

  // One clock: drive, push expectation, compare at negedge, advance model at posedge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic uv, input logic [7:0] uidx, input logic ut,
                       input logic um, input logic [7:0] ughr, input string tag);
    exp_t       e, s;
    logic [7:0] nghr;
    bp_if.pred_valid     = pv;
    bp_if.pred_pc        = pc;
    bp_if.pred_instr     = instr;
    bp_if.upd_valid      = uv;
    bp_if.upd_idx        = uidx;
    bp_if.upd_taken      = ut;
    bp_if.upd_mispredict = um;
    bp_if.upd_ghr        = ughr;
    e = model_pred(pc, instr);
    sb_q.push_back(e);
    @(negedge clk);
    s = sb_q.pop_front();
    check_val({tag, ".ready"}, 32'(bp_if.pred_ready), 32'(s.ready));
    check_val({tag, ".isb"},   32'(bp_if.pred_is_branch), 32'(s.isb));
    check_val({tag, ".taken"}, 32'(bp_if.pred_taken), 32'(s.tk));
    check_val({tag, ".idx"},   32'(bp_if.pred_idx), 32'(s.idx));
    check_val({tag, ".ghr"},   32'(bp_if.pred_ghr), 32'(s.ghr));
    @(posedge clk);
    if (!m_ready) begin
      m_tbl[m_cnt] = 2'b01;
      if (m_cnt == 255) m_ready = 1'b1;
      m_cnt++;
    end else begin
      nghr = m_ghr;
      if (pv && instr[6:0] == 7'h63) nghr = {m_ghr[6:0], e.tk};
      if (uv) begin
        if (ut) m_tbl[uidx] = (m_tbl[uidx] == 2'b11) ? 2'b11 : m_tbl[uidx] + 2'b01;
        else    m_tbl[uidx] = (m_tbl[uidx] == 2'b00) ? 2'b00 : m_tbl[uidx] - 2'b01;
        if (um) nghr = {ughr[6:0], ut};
      end
      m_ghr = nghr;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 32'h0, I_NOP, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, tag);
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_ghr   = 8'h00;
  endtask

  task automatic drive_quiet();
    bp_if.pred_valid     = 1'b0;
    bp_if.pred_pc        = '0;
    bp_if.pred_instr     = I_NOP;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_idx        = '0;
    bp_if.upd_taken      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
    bp_if.upd_ghr        = '0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bp_if.pred_ready !== 1'b1 && n < 400) begin
      idle(tag);
      n++;
    end
    check_val({tag, ".len"}, 32'(n), 32'd256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc2;
    logic [7:0]  g0;
    logic [31:0] ins;
    drive_quiet();
    model_reset();
    reset_n = 1'b0;

    // Reset state: everything masked, even for a jump presented during INIT.
    bp_if.pred_instr = I_JAL;
    bp_if.pred_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.ready", 32'(bp_if.pred_ready), 32'd0);
    check_val("rst.isb",   32'(bp_if.pred_is_branch), 32'd0);
    check_val("rst.taken", 32'(bp_if.pred_taken), 32'd0);
    drive_quiet();
    reset_n = 1'b1;

    // T1: init sweep length and every entry weakly not-taken.
    wait_ready("t1");
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 32'(i) << 2, I_B, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, "t1_entry");
    end

    // T2: saturation on idx 1 (ghr is 0 here, so gshare index equals pc index).
    pc2 = 32'h80000004;
    cycle(1'b0, pc2, I_B, 1'b0, 8'h01, 1'b0, 1'b0, 8'h0, "t2_init");
    check_val("t2_initial", 32'(bp_if.pred_taken), 32'd0);
    cycle(1'b0, pc2, I_B, 1'b1, 8'h01, 1'b1, 1'b0, 8'h0, "t2_up");
    check_val("t2_after1", 32'(bp_if.pred_taken), 32'd1);
    repeat (5) cycle(1'b0, pc2, I_B, 1'b1, 8'h01, 1'b1, 1'b0, 8'h0, "t2_up");
    cycle(1'b0, pc2, I_B, 1'b1, 8'h01, 1'b0, 1'b0, 8'h0, "t2_dn");
    check_val("t2_sat_hold", 32'(bp_if.pred_taken), 32'd1);
    repeat (2) cycle(1'b0, pc2, I_B, 1'b1, 8'h01, 1'b0, 1'b0, 8'h0, "t2_dn");
    check_val("t2_after_dn", 32'(bp_if.pred_taken), 32'd0);

    // T3: decode of jumps and a non-branch; history must not move.
    g0 = m_ghr;
    cycle(1'b1, 32'h200, I_JAL, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, "t3_jal");
    cycle(1'b1, 32'h204, I_JALR, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, "t3_jalr");
    cycle(1'b1, 32'h208, I_ADD, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, "t3_add");
    check_val("t3_ghr", 32'(bp_if.pred_ghr), 32'(g0));

    // T4: speculative not-taken shifts, then repair beating a same-cycle shift.
    repeat (3) cycle(1'b1, 32'h100, I_B, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, "t4_spec");
    check_val("t4_ghr0", 32'(bp_if.pred_ghr), 32'h00);
    cycle(1'b1, 32'h100, I_B, 1'b1, 8'h20, 1'b1, 1'b1, 8'h05, "t4_rep");
    check_val("t4_ghr_rep", 32'(bp_if.pred_ghr), 32'h0B);

    // T5: reset asserted mid-sweep restarts the full sweep.
    drive_quiet();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (100) idle("t5_pre");
    reset_n = 1'b0;
    model_reset();
    #1;
    check_val("t5_rst_ready", 32'(bp_if.pred_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("t5_hold_ready", 32'(bp_if.pred_ready), 32'd0);
    reset_n = 1'b1;
    wait_ready("t5");

    // T6: same-cycle predict and update to idx 0x12, no bypass.
    pc2 = {22'h0, (8'h12 ^ m_ghr), 2'b00};
    cycle(1'b0, pc2, I_B, 1'b1, 8'h12, 1'b1, 1'b0, 8'h0, "t6_same");
    check_val("t6_next", 32'(bp_if.pred_taken), 32'd1);

    // Random traffic exercising the gshare hash with non-zero history.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: ins = I_JAL;
        1: ins = I_ADD;
        default: ins = I_B;
      endcase
      cycle(1'($urandom_range(0, 1)), $urandom, ins,
            1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 8'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
